// File: rtl/event_logger_pkg.sv
// Shared widths and record layout for the event logger and its failure FIFO.
// A log record packs {a, b, s, idx} with idx in the low bits.
package event_logger_pkg;

  localparam int unsigned DefWidth    = 32;
  localparam int unsigned DefCntWidth = 32;

  function automatic int unsigned log_rec_w(input int unsigned w, input int unsigned cw);
    return 3 * w + cw;
  endfunction

  function automatic int unsigned off_idx();
    return 0;
  endfunction

  function automatic int unsigned off_s(input int unsigned cw);
    return cw;
  endfunction

  function automatic int unsigned off_b(input int unsigned w, input int unsigned cw);
    return cw + w;
  endfunction

  function automatic int unsigned off_a(input int unsigned w, input int unsigned cw);
    return cw + 2 * w;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word fall-through FIFO with synchronous flush; push is accepted when full
// if a pop happens in the same cycle.
module event_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [DataWidth-1:0]   data_i,
  input  logic                   pop_i,
  output logic [DataWidth-1:0]   data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0]   LvlFull = Depth[AddrW:0];
  localparam logic [AddrW:0]   LvlOne  = 1;
  localparam logic [AddrW-1:0] PtrOne  = 1;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AddrW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AddrW:0]       lvl_q, lvl_d;
  logic                 push_ok, pop_ok;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == LvlFull);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_q];
  assign level_o = lvl_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push_ok) wr_d = wr_q + PtrOne;
    if (pop_ok)  rd_d = rd_q + PtrOne;
    if (push_ok && !pop_ok)      lvl_d = lvl_q + LvlOne;
    else if (pop_ok && !push_ok) lvl_d = lvl_q - LvlOne;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset: the head is only meaningful while not empty.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/event_logger.sv
// Scores the DUT stream against the monitor's delayed mismatch event, keeps saturating
// pass/fail/drop counters and logs failing vectors into a FWFT FIFO.
module event_logger
  import event_logger_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned EVT_LATENCY = 3,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CNT_WIDTH   = DefCntWidth
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_dut_ia,
  input  logic [WIDTH-1:0]         i_dut_ib,
  input  logic [WIDTH-1:0]         i_dut_os,
  input  logic [WIDTH-1:0]         i_event,
  input  logic                     i_clear,
  output logic                     o_log_valid,
  input  logic                     i_log_ready,
  output logic [WIDTH-1:0]         o_log_a,
  output logic [WIDTH-1:0]         o_log_b,
  output logic [WIDTH-1:0]         o_log_s,
  output logic [CNT_WIDTH-1:0]     o_log_idx,
  output logic [CNT_WIDTH-1:0]     o_pass_cnt,
  output logic [CNT_WIDTH-1:0]     o_fail_cnt,
  output logic [CNT_WIDTH-1:0]     o_drop_cnt,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned RecW = log_rec_w(WIDTH, CNT_WIDTH);
  localparam int unsigned OffI = off_idx();
  localparam int unsigned OffS = off_s(CNT_WIDTH);
  localparam int unsigned OffB = off_b(WIDTH, CNT_WIDTH);
  localparam int unsigned OffA = off_a(WIDTH, CNT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CntOne = 1;

  logic [EVT_LATENCY-1:0] dv_q;
  logic [RecW-1:0]        dr_q [EVT_LATENCY];
  logic [CNT_WIDTH-1:0]   idx_q, idx_d, pass_q, pass_d, fail_q, fail_d, drop_q, drop_d;
  logic                   ovf_q, ovf_d;
  logic                   d_valid, pass_evt, fail_evt, pop, drop, fifo_full, fifo_empty;
  logic [RecW-1:0]        d_rec, head;

  assign d_valid  = dv_q[EVT_LATENCY-1];
  assign d_rec    = dr_q[EVT_LATENCY-1];
  assign pass_evt = d_valid && (i_event == '0);
  assign fail_evt = d_valid && (i_event != '0);
  assign pop      = o_log_valid && i_log_ready;
  assign drop     = fail_evt && fifo_full && !pop;

  // Delay line aligns each vector with the monitor's event for it; it never stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv_q <= '0;
      for (int i = 0; i < EVT_LATENCY; i++) dr_q[i] <= '0;
    end else begin
      dv_q[0] <= i_valid && !i_clear;
      dr_q[0] <= {i_dut_ia, i_dut_ib, i_dut_os, idx_q};
      for (int i = 1; i < EVT_LATENCY; i++) begin
        dv_q[i] <= dv_q[i-1] && !i_clear;
        dr_q[i] <= dr_q[i-1];
      end
    end
  end

  always_comb begin
    idx_d  = i_valid ? idx_q + CntOne : idx_q;
    pass_d = pass_q;
    fail_d = fail_q;
    drop_d = drop_q;
    ovf_d  = ovf_q || drop;
    if (pass_evt && pass_q != '1) pass_d = pass_q + CntOne;
    if (fail_evt && fail_q != '1) fail_d = fail_q + CntOne;
    if (drop && drop_q != '1)     drop_d = drop_q + CntOne;
    if (i_clear) begin
      idx_d  = '0;
      pass_d = '0;
      fail_d = '0;
      drop_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      pass_q <= '0;
      fail_q <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  event_fifo #(
    .DataWidth (RecW),
    .Depth     (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (i_clear),
    .push_i  (fail_evt),
    .data_i  (d_rec),
    .pop_i   (i_log_ready),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_level)
  );

  assign o_log_valid = !fifo_empty;
  assign o_log_a     = head[OffA +: WIDTH];
  assign o_log_b     = head[OffB +: WIDTH];
  assign o_log_s     = head[OffS +: WIDTH];
  assign o_log_idx   = head[OffI +: CNT_WIDTH];
  assign o_pass_cnt  = pass_q;
  assign o_fail_cnt  = fail_q;
  assign o_drop_cnt  = drop_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_event_logger.sv
// Directed bench: expected log records are queued at stimulus time and a forked monitor
// pops and compares them whenever the logger hands one over.
module tb_event_logger;

  localparam int unsigned W  = 32;
  localparam int unsigned L  = 3;
  localparam int unsigned D  = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_valid = 1'b0, i_clear = 1'b0, i_log_ready = 1'b0;
  logic [W-1:0]  i_dut_ia = '0, i_dut_ib = '0, i_dut_os = '0, i_event = '0;
  logic          o_log_valid, o_overflow;
  logic [W-1:0]  o_log_a, o_log_b, o_log_s;
  logic [CW-1:0] o_log_idx, o_pass_cnt, o_fail_cnt, o_drop_cnt;
  logic [LW-1:0] o_level;

  always #5 clk = ~clk;

  event_logger #(
    .WIDTH       (W),
    .EVT_LATENCY (L),
    .DEPTH       (D),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_dut_ia    (i_dut_ia),
    .i_dut_ib    (i_dut_ib),
    .i_dut_os    (i_dut_os),
    .i_event     (i_event),
    .i_clear     (i_clear),
    .o_log_valid (o_log_valid),
    .i_log_ready (i_log_ready),
    .o_log_a     (o_log_a),
    .o_log_b     (o_log_b),
    .o_log_s     (o_log_s),
    .o_log_idx   (o_log_idx),
    .o_pass_cnt  (o_pass_cnt),
    .o_fail_cnt  (o_fail_cnt),
    .o_drop_cnt  (o_drop_cnt),
    .o_overflow  (o_overflow),
    .o_level     (o_level)
  );

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  s;
    logic [CW-1:0] idx;
  } rec_t;

  rec_t          exp_q[$];
  int            n_vec = 0;
  int            n_miss = 0;
  int            cyc = 0;
  logic          vflag [4096];
  logic          mflag [4096];
  logic [CW-1:0] idx_m = '0;
  logic          rdy_nxt = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs #1 after the edge and play back the monitor event L cycles late.
  task automatic tick(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] s, input logic mis, input logic keep,
                      input logic clr);
    rec_t r;
    @(posedge clk);
    #1;
    if (i_clear) begin
      exp_q.delete();
      idx_m = '0;
    end
    cyc++;
    i_valid     = v;
    i_dut_ia    = a;
    i_dut_ib    = b;
    i_dut_os    = s;
    i_clear     = clr;
    i_log_ready = rdy_nxt;
    vflag[cyc]  = v;
    mflag[cyc]  = mis;
    if (cyc > L && vflag[cyc-L]) i_event = mflag[cyc-L] ? 32'h0000_0100 : 32'h0;
    else                         i_event = 32'hBAD0_BAD0;  // must be ignored
    if (v) begin
      if (keep) begin
        r.a = a; r.b = b; r.s = s; r.idx = idx_m;
        exp_q.push_back(r);
      end
      idx_m = idx_m + 1'b1;
    end
  endtask

  task automatic vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s,
                     input logic mis, input logic keep);
    tick(1'b1, a, b, s, mis, keep, 1'b0);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    tick(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle_n(1);
  endtask

  task automatic drain(input string name);
    rdy_nxt = 1'b1;
    for (int k = 0; k < 20; k++) begin
      idle_n(1);
      if (!o_log_valid) break;
    end
    rdy_nxt = 1'b0;
    chk(name, o_log_valid, 0);
  endtask

  task automatic monitor();
    rec_t e;
    forever begin
      @(negedge clk);
      if (o_log_valid && i_log_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL log_unexpected: got idx %0h expected no entry", o_log_idx);
        end else begin
          e = exp_q.pop_front();
          chk("log_entry", {o_log_a, o_log_b, o_log_s, o_log_idx}, e);
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_log_valid, 0);
    chk({tag, "_pass"},  o_pass_cnt, 0);
    chk({tag, "_fail"},  o_fail_cnt, 0);
    chk({tag, "_drop"},  o_drop_cnt, 0);
    chk({tag, "_ovf"},   o_overflow, 0);
    chk({tag, "_level"}, o_level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk);
    #1 reset = 1'b1;

    // All vectors pass; one bubble with garbage on the event line.
    for (int i = 0; i < 10; i++) begin
      vec(i, i + 1, 2 * i + 1, 1'b0, 1'b0);
      if (i == 4) idle_n(1);
    end
    idle_n(L + 1);
    chk("t1_pass", o_pass_cnt, 10);
    chk("t1_fail", o_fail_cnt, 0);
    chk("t1_valid", o_log_valid, 0);

    // Single mismatch on idx 2; log appears L+1 cycles after presentation.
    do_clear();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) vec(32'h5, 32'h7, 32'hD, 1'b1, 1'b1);
      else        vec(i, i, 2 * i, 1'b0, 1'b0);
    end
    chk("t2_lat_pre", o_log_valid, 0);
    idle_n(1);
    chk("t2_lat", o_log_valid, 1);
    idle_n(3);
    chk("t2_fail", o_fail_cnt, 1);
    chk("t2_pass", o_pass_cnt, 5);
    chk("t2_level", o_level, 1);
    drain("t2_drain");

    // Overflow: 10 failures into 8 entries.
    do_clear();
    for (int i = 0; i < 10; i++) vec(32'h100 + i, 32'h200 + i, 32'h300 + i, 1'b1, i < 8);
    idle_n(L + 1);
    chk("t3_level", o_level, 8);
    chk("t3_drop", o_drop_cnt, 2);
    chk("t3_ovf", o_overflow, 1);
    chk("t3_fail", o_fail_cnt, 10);
    drain("t3_drain");

    // Full FIFO, pop coincides with a new failure: nothing dropped.
    do_clear();
    for (int i = 0; i < 8; i++) vec(32'h40 + i, 32'h50 + i, 32'h60 + i, 1'b1, 1'b1);
    idle_n(L + 1);
    chk("t4_full", o_level, 8);
    vec(32'hAAAA, 32'hBBBB, 32'hCCCC, 1'b1, 1'b1);
    idle_n(2);
    rdy_nxt = 1'b1;
    idle_n(1);
    rdy_nxt = 1'b0;
    idle_n(1);
    chk("t4_level", o_level, 8);
    chk("t4_drop", o_drop_cnt, 0);
    chk("t4_fail", o_fail_cnt, 9);
    chk("t4_ovf", o_overflow, 0);
    drain("t4_drain");

    // Clear with a full FIFO, overflow set and two vectors in flight.
    do_clear();
    for (int i = 0; i < 9; i++) vec(i, i, i, 1'b1, 1'b0);
    vec(32'h9, 32'h9, 32'h9, 1'b0, 1'b0);
    idle_n(L + 1);
    chk("t5_pre_ovf", o_overflow, 1);
    chk("t5_pre_pass", o_pass_cnt, 1);
    vec(32'hE1, 32'hE2, 32'hE3, 1'b1, 1'b0);
    vec(32'hF1, 32'hF2, 32'hF3, 1'b1, 1'b0);
    do_clear();
    chk_all_zero("t5_clr");
    idle_n(L + 1);
    chk("t5_inflight", o_fail_cnt, 0);
    vec(32'hA, 32'hB, 32'h15, 1'b1, 1'b1);
    idle_n(L + 1);
    chk("t5_after", o_fail_cnt, 1);
    drain("t5_drain");

    // Saturation, then asynchronous reset in the middle of a burst.
    do_clear();
    for (int i = 0; i < 20; i++) vec(32'h1000 + i, 32'h2000 + i, 32'h3000 + i, 1'b1, i < 8);
    idle_n(L + 1);
    chk("t6_sat", o_fail_cnt, 15);
    chk("t6_drop", o_drop_cnt, 12);
    chk("t6_level", o_level, 8);
    for (int i = 0; i < 6; i++) vec(i, i, i, 1'b1, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    exp_q.delete();
    idx_m = '0;
    idle_n(1);
    reset = 1'b1;
    vec(32'h77, 32'h88, 32'hFF, 1'b1, 1'b1);
    idle_n(L + 1);
    chk("t6_after", o_fail_cnt, 1);
    drain("t6_drain");

    chk("log_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
